// File: rtl/gray_stream_checker.sv
// Registers and decodes a gray-coded counter stream, checks single steps.
// Optional macro GRAY_DOWN_EN: also accept decrements and report dir_down.
module gray_stream_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_N    = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 out_valid,
  output logic                 step_err,
  output logic                 locked,
  output logic                 dir_down,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     g1_q;
  logic                 v1_q;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     bin_q, bin_d, dec;
  logic                 ov_q, err_q, err_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;
  logic                 is_stall, is_up, is_dn, is_good;

  // S1: capture the raw sample and its qualifier
  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      g1_q <= gray_in;
      v1_q <= in_valid;
    end
  end

  // Gray to binary: each bit is the xor of all gray bits at or above it
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(g1_q >> i);
    end
  end

  // Classify the decoded sample against the held reference
  always_comb begin
    is_stall = (dec == ref_q);
    is_up    = (dec == ref_q + WIDTH'(1));
`ifdef GRAY_DOWN_EN
    is_dn    = (dec == ref_q - WIDTH'(1));
`else
    is_dn    = 1'b0;
`endif
    is_good  = is_up | is_dn;
  end

`ifdef GRAY_DOWN_EN
  logic dir_q, dir_d;
`endif

  // Next state, reference tracking and S2 output values
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    errc_d  = errc_q;
    bin_d   = v1_q ? dec : bin_q;
`ifdef GRAY_DOWN_EN
    dir_d   = dir_q;
`endif
    if (v1_q) begin
      unique case (state_q)
        UNLOCKED: begin
          ref_d   = dec;
          cnt_d   = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (is_good) begin
            ref_d = dec;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(LOCK_N)) begin
              state_d = LOCKED;
            end
`ifdef GRAY_DOWN_EN
            dir_d = is_dn;
`endif
          end else if (!is_stall) begin
            ref_d = dec;
            cnt_d = '0;
          end
        end
        LOCKED: begin
          if (is_good) begin
            ref_d = dec;
`ifdef GRAY_DOWN_EN
            dir_d = is_dn;
`endif
          end else if (!is_stall) begin
            err_d   = 1'b1;
            ref_d   = dec;
            cnt_d   = '0;
            state_d = ACQUIRE;
            if (errc_q != '1) begin
              errc_d = errc_q + ERR_CNT_W'(1);
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // S2: FSM, reference and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ref_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ov_q    <= v1_q;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

`ifdef GRAY_DOWN_EN
  // Direction of the last accepted step
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
  assign dir_down = dir_q;
`else
  assign dir_down = 1'b0;
`endif

  assign bin_out   = bin_q;
  assign out_valid = ov_q;
  assign step_err  = err_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = errc_q;

endmodule

// File: tb/tb_gray_stream_checker.sv
// Directed bench for gray_stream_checker (default and 2-bit error counter).
// Expected results follow the GRAY_DOWN_EN macro when it is defined.
module tb_gray_stream_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       in_valid;

  logic [3:0] bin_out, bin_out2;
  logic       out_valid, out_valid2;
  logic       step_err, step_err2;
  logic       locked, locked2;
  logic       dir_down, dir_down2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray_stream_checker #(.WIDTH(4), .LOCK_N(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out), .out_valid(out_valid), .step_err(step_err),
    .locked(locked), .dir_down(dir_down), .err_count(err_count)
  );

  gray_stream_checker #(.WIDTH(4), .LOCK_N(3), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out2), .out_valid(out_valid2), .step_err(step_err2),
    .locked(locked2), .dir_down(dir_down2), .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] g, input logic v);
    gray_in  = g;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] g);
    step(g, 1'b1);
    step(4'b0, 1'b0);
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  int r;
  int e1[5];
  int e2[5];

  initial begin
    rst = 1'b1;
    gray_in = '0;
    in_valid = 1'b0;
    step(4'b0, 1'b0);
    step(4'b0, 1'b0);
    check("rst_bin", bin_out, 0);
    check("rst_ov", out_valid, 0);
    check("rst_err", step_err, 0);
    check("rst_lock", locked, 0);
    check("rst_dir", dir_down, 0);
    check("rst_cnt", err_count, 0);
    check("rst2_bin", bin_out2, 0);
    check("rst2_ov", out_valid2, 0);
    check("rst2_err", step_err2, 0);
    check("rst2_lock", locked2, 0);
    check("rst2_dir", dir_down2, 0);
    check("rst2_cnt", err_count2, 0);
    rst = 1'b0;

    // full up-count with wrap, in_valid every cycle
    for (int i = 0; i <= 16; i++) begin
      step(to_gray(i), 1'b1);
      if (i > 0) begin
        check("t1_bin", bin_out, 32'(i - 1));
        check("t1_ov", out_valid, 1);
        check("t1_err", step_err, 0);
        check("t1_lock", locked, (i - 1 >= 3) ? 1 : 0);
      end
    end
    step(4'b0, 1'b0);
    check("t1_wrap_bin", bin_out, 0);
    check("t1_wrap_err", step_err, 0);
    check("t1_wrap_lock", locked, 1);

    // bad step while locked, then reacquire
    send(4'b0001); send(4'b0011); send(4'b0010);
    send(4'b0110); send(4'b0111);
    check("t2_pre_lock", locked, 1);
    check("t2_pre_bin", bin_out, 5);
    check("t2_pre_dir", dir_down, 0);
    step(4'b1100, 1'b1);
    step(4'b0, 1'b0);
    check("t2_bin", bin_out, 8);
    check("t2_err", step_err, 1);
    check("t2_cnt", err_count, 1);
    check("t2_lock", locked, 0);
    step(4'b0, 1'b0);
    check("t2_pulse", step_err, 0);
    send(4'b1101);
    check("t2_l9", locked, 0);
    send(4'b1111);
    check("t2_l10", locked, 0);
    send(4'b1110);
    check("t2_bin11", bin_out, 11);
    check("t2_relock", locked, 1);

    // stalls and gaps
    send(4'b1010); send(4'b1011); send(4'b1001); send(4'b1000);
    send(4'b0000); send(4'b0001); send(4'b0011);
    check("t3_pre_lock", locked, 1);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    check("t3_stall_err", step_err, 0);
    step(4'b0, 1'b0);
    check("t3_stall_bin", bin_out, 3);
    check("t3_stall_ov", out_valid, 1);
    step(4'b0, 1'b0);
    check("t3_gap_ov", out_valid, 0);
    check("t3_gap_bin", bin_out, 3);
    check("t3_gap_err", step_err, 0);
    step(4'b0, 1'b0);
    check("t3_gap_ov2", out_valid, 0);
    step(4'b0110, 1'b1);
    check("t3_gap_ov3", out_valid, 0);
    step(4'b0, 1'b0);
    check("t3_bin4", bin_out, 4);
    check("t3_err4", step_err, 0);
    check("t3_lock4", locked, 1);
    check("t3_cnt", err_count, 1);

    // reset mid-stream with a sample in flight
    send(4'b1100);
    check("t4_err", step_err, 1);
    send(4'b1101); send(4'b1111); send(4'b1110);
    check("t4_pre_lock", locked, 1);
    check("t4_pre_cnt", err_count, 2);
    rst = 1'b1;
    step(4'b1111, 1'b1);
    rst = 1'b0;
    check("t4_bin", bin_out, 0);
    check("t4_ov", out_valid, 0);
    check("t4_err0", step_err, 0);
    check("t4_lock", locked, 0);
    check("t4_cnt", err_count, 0);
    step(4'b0, 1'b0);
    check("t4_flush_ov", out_valid, 0);
    send(4'b1010);
    check("t4_first_bin", bin_out, 12);
    check("t4_first_ov", out_valid, 1);
    check("t4_first_err", step_err, 0);
    check("t4_first_lock", locked, 0);

    // repeated bad steps from LOCKED, saturation of 2-bit counter
    e1 = '{1, 2, 3, 4, 5};
    e2 = '{1, 2, 3, 3, 3};
    r = 12;
    for (int k = 0; k < 5; k++) begin
      send(to_gray(r + 1));
      send(to_gray(r + 2));
      send(to_gray(r + 3));
      check("t5_lock", locked, 1);
      check("t5_lock2", locked2, 1);
      r = (r + 8) % 16;
      send(to_gray(r));
      check("t5_err", step_err, 1);
      check("t5_err2", step_err2, 1);
      check("t5_cnt", err_count, 32'(e1[k]));
      check("t5_cnt2", err_count2, 32'(e2[k]));
    end

    // decrement while locked
    rst = 1'b1;
    step(4'b0, 1'b0);
    rst = 1'b0;
    send(4'b0001); send(4'b0011); send(4'b0010);
    send(4'b0110); send(4'b0111);
    check("t6_pre_lock", locked, 1);
    send(4'b0110);
    check("t6_bin", bin_out, 4);
`ifdef GRAY_DOWN_EN
    check("t6_err", step_err, 0);
    check("t6_dir", dir_down, 1);
    check("t6_lock", locked, 1);
    check("t6_cnt", err_count, 0);
`else
    check("t6_err", step_err, 1);
    check("t6_dir", dir_down, 0);
    check("t6_lock", locked, 0);
    check("t6_cnt", err_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_stream_checker.md
Name: gray_stream_checker

Overview:
Consumer stage placed directly after the gray-code counter. It registers the incoming gray word and decodes it to binary. It checks that every new sample is a legal single step of the counter sequence, and keeps lock and error status for the link. Typical use is monitoring a gray count sent across a module boundary. Single clock domain.

Parameters:
WIDTH, 4, width of gray_in and bin_out.
LOCK_N, 3, number of consecutive good steps needed to assert locked (1..15).
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
gray_in  input  WIDTH  gray-coded sample
in_valid  input  1  gray_in qualifier
bin_out  output  WIDTH  decoded binary of the sample
out_valid  output  1  bin_out/step_err qualifier
step_err  output  1  one-cycle pulse, illegal step detected
locked  output  1  stream tracked as legal
dir_down  output  1  last accepted step was a decrement (GRAY_DOWN_EN only; else 0)
err_count  output  ERR_CNT_W  saturating count of step errors

Behaviour:
- Reset: rst is sampled on the clk edge (synchronous, active-high). All outputs, pipeline registers and FSM return to 0/UNLOCKED on the edge after rst=1.
- Pipeline: 2 stages.
  - S1 registers gray_in and in_valid.
  - S2 decodes bin[WIDTH-1]=g[WIDTH-1], bin[i]=bin[i+1]^g[i] and registers bin_out, out_valid, step_err, locked, dir_down.
  - Sample taken at edge N appears on the outputs after edge N+1 (latency 2).
  - No backpressure.
- Reference:
  - ref_bin holds the binary value of the last valid sample. It is held unchanged across in_valid=0 gaps.
  - Invalid cycles give out_valid=0 and step_err=0. bin_out holds its last value.
- Step classification (for valid samples after the first):
  - STALL: bin == ref_bin.
  - GOOD: bin == ref_bin+1 mod 2^WIDTH. Wrap from all-ones to 0 is GOOD.
  - BAD: anything else.
- FSM states: UNLOCKED, ACQUIRE, LOCKED.
  - UNLOCKED: first valid sample loads ref_bin, clears good_cnt, goes to ACQUIRE. No error.
  - ACQUIRE:
    - GOOD: good_cnt++. When good_cnt reaches LOCK_N, go to LOCKED.
    - BAD: reload ref_bin, clear good_cnt, no step_err, stay in ACQUIRE.
    - STALL: no change.
  - LOCKED:
    - GOOD or STALL: stay in LOCKED.
    - BAD: step_err=1 for that output cycle, err_count+1, reload ref_bin, clear good_cnt, go to ACQUIRE.
- locked=1 exactly while the FSM is in LOCKED. It updates in the same output cycle as the transition.
- err_count saturates at 2^ERR_CNT_W-1. It is cleared only by rst.
- rst mid-stream: in-flight S1 data is discarded. Next valid sample after rst is handled as the first sample.

Optional Feature:
GRAY_DOWN_EN
- Defined:
  - bin == ref_bin-1 mod 2^WIDTH is also GOOD. This includes 0 to all-ones.
  - dir_down updates on each GOOD step: 1 for a decrement, 0 for an increment. It holds on STALL.
- Undefined:
  - Decrement steps are BAD.
  - dir_down is tied to 0.

Test Plan:
1. After rst, stream gray 0000,0001,0011,…,1000,0000 with in_valid=1 every cycle.
   - Required: bin_out 0..15 then 0, each 2 cycles after input.
   - Required: locked rises with the 4th sample (bin 3); step_err never asserts; wrap 15 to 0 accepted.
2. While locked at 0111 (bin 5), drive 1100 (bin 8).
   - Required: one-cycle step_err, err_count=1, locked=0.
   - Then 1101 (bin 9), 1111 (10), 1110 (11): locked=1 again with bin 11.
3. While locked, drive repeated 0010 samples and insert 3 cycles of in_valid=0, then drive 0110.
   - Required: no step_err; out_valid=0 during gaps; bin_out=4 accepted against held ref 3.
4. Assert rst for 1 cycle mid-stream (locked=1, err_count=2).
   - Required: after that edge all outputs 0 and state UNLOCKED.
   - Then the first valid sample 1010 raises no error.
5. ERR_CNT_W=2: generate 5 BAD steps, each from LOCKED.
   - Required: err_count sequence 1,2,3,3,3; step_err pulses 5 times.
6. Locked at 0111 (5), drive 0110 (4).
   - With GRAY_DOWN_EN: no error, dir_down=1.
   - Without: step_err=1, err_count+1, dir_down=0.
